// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter constants and helpers
package arb_pkg;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int lowestLevel(input int n);
        return n - 1;
    endfunction
    localparam int ARB_REQ_NUM    = 4;
    localparam int ARB_LVL_W      = clog2(ARB_REQ_NUM);
    localparam int ARB_LOWEST_LVL = lowestLevel(ARB_REQ_NUM);
endpackage

// File: rtl/arb_lru_pick.sv
// arb_lru_pick: picks the asserted request holding the smallest priority level
module arb_lru_pick
    import arb_pkg::*;
#(
    parameter int REQ_NUM = ARB_REQ_NUM,
    localparam int LVL_W = clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]       req,
    input  logic [REQ_NUM*LVL_W-1:0] levels,
    output logic [REQ_NUM-1:0]       winOneHot,
    output logic [LVL_W-1:0]         winId,
    output logic                     anyReq
);
    logic [LVL_W-1:0] bestLvl;
    always_comb begin
        winId = '0;
        bestLvl = LVL_W'(lowestLevel(REQ_NUM));
        anyReq = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (req[i] && (!anyReq || levels[i*LVL_W +: LVL_W] < bestLvl)) begin
                winId = LVL_W'(i);
                bestLvl = levels[i*LVL_W +: LVL_W];
                anyReq = 1'b1;
            end
        end
        winOneHot = anyReq ? REQ_NUM'(1) << winId : '0;
    end
endmodule

// File: rtl/arb_weighted_lru.sv
// arb_weighted_lru: LRU arbiter with per-requester burst quotas and encoded grant
module arb_weighted_lru
    import arb_pkg::*;
#(
    parameter int REQ_NUM = ARB_REQ_NUM,
    parameter int WEIGHT_W = 4,
    localparam int LVL_W = clog2(REQ_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REQ_NUM-1:0]  req,
    input  logic                cfg_we,
    input  logic [LVL_W-1:0]    cfg_idx,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    output logic [REQ_NUM-1:0]  grant,
    output logic [LVL_W-1:0]    grant_id,
    output logic                grant_valid,
    output logic                grant_last
);
    localparam logic [LVL_W-1:0] LOWEST = LVL_W'(lowestLevel(REQ_NUM));
    logic [REQ_NUM*LVL_W-1:0] levels, nextLevels;
    logic [WEIGHT_W-1:0]      weights [REQ_NUM];
    logic [WEIGHT_W-1:0]      cnt, load;
    logic [REQ_NUM-1:0]       winOneHot;
    logic [LVL_W-1:0]         winId, winLvl, lvl;
    logic                     anyReq, hold;

    arb_lru_pick #(.REQ_NUM(REQ_NUM)) pick (
        .req(req), .levels(levels), .winOneHot(winOneHot), .winId(winId), .anyReq(anyReq)
    );

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < REQ_NUM; i++) grant_id = grant[i] ? LVL_W'(i) : grant_id;
        grant_valid = |grant;
        grant_last = grant_valid && cnt == WEIGHT_W'(1);
        hold = grant_valid && req[grant_id] && cnt > WEIGHT_W'(1);
        load = weights[winId] == '0 ? WEIGHT_W'(1) : weights[winId];
        winLvl = levels[winId*LVL_W +: LVL_W];
        nextLevels = levels;
        for (int j = 0; j < REQ_NUM; j++) begin
            lvl = levels[j*LVL_W +: LVL_W];
            nextLevels[j*LVL_W +: LVL_W] = LVL_W'(j) == winId ? LOWEST :
                                           lvl > winLvl ? lvl - LVL_W'(1) : lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                levels[i*LVL_W +: LVL_W] <= LVL_W'(i);
                weights[i] <= WEIGHT_W'(1);
            end
            grant <= '0;
            cnt <= '0;
        end else begin
            // quota changes land in the register only; the running burst keeps its cnt
            if (cfg_we && {1'b0, cfg_idx} < (LVL_W+1)'(REQ_NUM)) weights[cfg_idx] <= cfg_weight;
            if (hold) begin
                cnt <= cnt - WEIGHT_W'(1);
            end else if (anyReq) begin
                grant <= winOneHot;
                cnt <= load;
                levels <= nextLevels;
            end else begin
                grant <= '0;
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_arb_weighted_lru.sv
// tb_arb_weighted_lru: directed scoreboard bench for the weighted LRU arbiter
module tb_arb_weighted_lru;
    logic       clk = 0, rst = 1;
    logic [3:0] req = '0, grant;
    logic       cfg_we = 0, grant_valid, grant_last;
    logic [1:0] cfg_idx = '0, grant_id;
    logic [3:0] cfg_weight = '0;
    logic [2:0] req3 = '0, grant3;
    logic       cfgWe3 = 0, grantValid3, grantLast3;
    logic [1:0] cfgIdx3 = '0, grantId3;
    logic [3:0] cfgWeight3 = '0;
    int total = 0, passed = 0;
    logic [4:0] sb [$];

    always #5 clk = ~clk;

    arb_weighted_lru #(.REQ_NUM(4), .WEIGHT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_weight(cfg_weight), .grant(grant), .grant_id(grant_id),
        .grant_valid(grant_valid), .grant_last(grant_last)
    );

    arb_weighted_lru #(.REQ_NUM(3), .WEIGHT_W(4)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .cfg_we(cfgWe3), .cfg_idx(cfgIdx3),
        .cfg_weight(cfgWeight3), .grant(grant3), .grant_id(grantId3),
        .grant_valid(grantValid3), .grant_last(grantLast3)
    );

    function automatic logic [1:0] encId(input logic [3:0] g);
        logic [1:0] r = '0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] g, input logic l);
        logic [4:0] e;
        req = r;
        sb.push_back({g, l});
        @(posedge clk);
        #1;
        cfg_we = 0;
        e = sb.pop_front();
        chk({tag, ".grant"}, 8'(grant), 8'(e[4:1]));
        chk({tag, ".id"}, 8'(grant_id), 8'(encId(e[4:1])));
        chk({tag, ".valid"}, 8'(grant_valid), 8'(|e[4:1]));
        chk({tag, ".last"}, 8'(grant_last), 8'(e[0]));
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [3:0] w);
        cfg_we = 1;
        cfg_idx = idx;
        cfg_weight = w;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.grant", 8'(grant), 8'h00);
        chk("rst.flags", 8'({grant_id, grant_valid, grant_last}), 8'h00);
        chk("rst.levels", dut.levels, 8'b11100100);
        rst = 0;
        // round robin with unit weights
        step("rr0", 4'b1111, 4'b0001, 1);
        step("rr1", 4'b1111, 4'b0010, 1);
        step("rr2", 4'b1111, 4'b0100, 1);
        step("rr3", 4'b1111, 4'b1000, 1);
        step("rr4", 4'b1111, 4'b0001, 1);
        cfg(2'd1, 4'd3);
        step("idle0", 4'b0000, 4'b0000, 0);
        // levels now 3,0,1,2 -> requester 1 wins first
        step("w3a", 4'b0011, 4'b0010, 0);
        step("w3b", 4'b0011, 4'b0010, 0);
        step("w3c", 4'b0011, 4'b0010, 1);
        step("w3d", 4'b0011, 4'b0001, 1);
        step("w3e", 4'b0011, 4'b0010, 0);
        step("w3f", 4'b0011, 4'b0010, 0);
        step("w3g", 4'b0011, 4'b0010, 1);
        step("w3h", 4'b0011, 4'b0001, 1);
        cfg(2'd2, 4'd2);
        step("idle1", 4'b0000, 4'b0000, 0);
        step("sole0", 4'b0100, 4'b0100, 0);
        chk("sole.lv0", dut.levels, 8'b00110110);
        step("sole1", 4'b0100, 4'b0100, 1);
        step("sole2", 4'b0100, 4'b0100, 0);
        step("sole3", 4'b0100, 4'b0100, 1);
        step("sole4", 4'b0100, 4'b0100, 0);
        chk("sole.lv1", dut.levels, 8'b00110110);
        cfg(2'd3, 4'd5);
        step("idle2", 4'b0000, 4'b0000, 0);
        step("drop0", 4'b1000, 4'b1000, 0);
        chk("drop.lv3a", 8'(dut.levels[7:6]), 8'd3);
        step("drop1", 4'b1000, 4'b1000, 0);
        chk("drop.lv3b", 8'(dut.levels[7:6]), 8'd3);
        step("drop2", 4'b0001, 4'b0001, 1);
        cfg(2'd0, 4'd0);
        step("idle3", 4'b0000, 4'b0000, 0);
        step("zw0", 4'b0001, 4'b0001, 1);
        step("zw1", 4'b0001, 4'b0001, 1);
        step("zw2", 4'b0001, 4'b0001, 1);
        cfg(2'd3, 4'd4);
        step("idle4", 4'b0000, 4'b0000, 0);
        step("mid0", 4'b1000, 4'b1000, 0);
        step("mid1", 4'b1000, 4'b1000, 0);
        rst = 1;
        step("mid.rst", 4'b1000, 4'b0000, 0);
        chk("mid.levels", dut.levels, 8'b11100100);
        rst = 0;
        step("post0", 4'b1111, 4'b0001, 1);
        step("post1", 4'b1111, 4'b0010, 1);
        step("post2", 4'b1111, 4'b0100, 1);
        step("post3", 4'b1111, 4'b1000, 1);
        // write coinciding with grant start keeps the old quota for that burst
        cfg(2'd0, 4'd3);
        step("coin0", 4'b0001, 4'b0001, 1);
        step("coin1", 4'b0001, 4'b0001, 0);
        step("coin2", 4'b0001, 4'b0001, 0);
        step("coin3", 4'b0001, 4'b0001, 1);
        step("idle5", 4'b0000, 4'b0000, 0);
        // out-of-range index on a 3-requester instance must be dropped
        cfgWe3 = 1;
        cfgIdx3 = 2'd3;
        cfgWeight3 = 4'd5;
        @(posedge clk);
        #1;
        cfgWe3 = 0;
        req3 = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("oor%0d.grant", k), 8'(grant3), 8'(3'b001 << (k % 3)));
            chk($sformatf("oor%0d.last", k), 8'({grantId3, grantValid3, grantLast3}), 8'({2'(k % 3), 2'b11}));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
